// File: rtl/collectible_pool.sv
// Multi-slot collectible controller: a shared spawn scheduler feeding NUM_SLOTS
// independent boxes that fly right-to-left along an up/down arc.
module collectible_pool #(
   parameter int unsigned NUM_SLOTS        = 4,
   parameter int unsigned BOX_WIDTH        = 30,
   parameter int unsigned BOX_HEIGHT       = 30,
   parameter int unsigned BOX_SPEED        = 6,
   parameter int unsigned X_START          = 640,
   parameter int unsigned Y_BASELINE       = 315,
   parameter int unsigned Y_INITIAL_OFFSET = 50,
   parameter int unsigned Y_STEP           = 3,
   parameter int unsigned SPAWN_GAP        = 20,
   parameter int unsigned MAX_HELD         = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      game_en,
   input  logic [NUM_SLOTS-1:0]      caught,
   input  logic [9:0]                y_amplitude_in,
   input  logic [3:0]                held_count,
   output logic [10*NUM_SLOTS-1:0]   box_x_pos,
   output logic [10*NUM_SLOTS-1:0]   box_y_pos,
   output logic [9:0]                box_width,
   output logic [9:0]                box_height,
   output logic [NUM_SLOTS-1:0]      active,
   output logic                      spawn_pulse,
   output logic                      miss_pulse
);

   localparam int unsigned XW      = 10;
   localparam int unsigned YW      = 11;
   localparam int unsigned GW      = $clog2(SPAWN_GAP + 1);
   localparam int unsigned IW      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned Y_FLOOR = Y_BASELINE - BOX_HEIGHT;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } slot_state_t;

   slot_state_t       state   [NUM_SLOTS];
   logic [XW-1:0]     x_q     [NUM_SLOTS];
   logic [YW-1:0]     y_off_q [NUM_SLOTS];
   logic [YW-1:0]     amp_q   [NUM_SLOTS];
   logic [GW-1:0]     gap_cnt;

   logic              grant_en;
   logic [IW-1:0]     grant_idx;
   logic              miss_any;

   // Lowest-index idle slot wins; only pre-edge idle slots are candidates.
   always_comb begin
      grant_en  = 1'b0;
      grant_idx = '0;
      if (gap_cnt == GW'(SPAWN_GAP) && held_count < 4'(MAX_HELD)) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!grant_en && state[i] == S_IDLE) begin
               grant_en  = 1'b1;
               grant_idx = IW'(i);
            end
         end
      end
   end

   // Any flying, uncaught slot about to leave the left edge.
   always_comb begin
      miss_any = 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (state[i] != S_IDLE && !caught[i] && x_q[i] < XW'(BOX_SPEED))
            miss_any = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            state[i]   <= S_IDLE;
            x_q[i]     <= XW'(X_START);
            y_off_q[i] <= YW'(Y_INITIAL_OFFSET);
            amp_q[i]   <= '0;
         end
         active      <= '0;
         gap_cnt     <= '0;
         spawn_pulse <= 1'b0;
         miss_pulse  <= 1'b0;
      end else if (!game_en) begin
         spawn_pulse <= 1'b0;
         miss_pulse  <= 1'b0;
      end else begin
         spawn_pulse <= grant_en;
         miss_pulse  <= miss_any;

         if (grant_en)
            gap_cnt <= '0;
         else if (gap_cnt < GW'(SPAWN_GAP))
            gap_cnt <= gap_cnt + GW'(1);

         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (state[i] == S_IDLE) begin
               if (grant_en && grant_idx == IW'(i)) begin
                  state[i]   <= S_UP;
                  x_q[i]     <= XW'(X_START);
                  y_off_q[i] <= YW'(Y_INITIAL_OFFSET);
                  amp_q[i]   <= YW'(y_amplitude_in);
                  active[i]  <= 1'b1;
               end
            end else if (caught[i] || x_q[i] < XW'(BOX_SPEED)) begin
               // Catch or left-edge exit returns the slot to its idle position.
               state[i]   <= S_IDLE;
               x_q[i]     <= XW'(X_START);
               y_off_q[i] <= YW'(Y_INITIAL_OFFSET);
               active[i]  <= 1'b0;
            end else begin
               x_q[i] <= x_q[i] - XW'(BOX_SPEED);
               if (state[i] == S_UP) begin
                  if (y_off_q[i] < YW'(Y_INITIAL_OFFSET) + amp_q[i])
                     y_off_q[i] <= y_off_q[i] + YW'(Y_STEP);
                  else
                     state[i] <= S_DOWN;
               end else begin
                  y_off_q[i] <= (y_off_q[i] > YW'(Y_STEP)) ? y_off_q[i] - YW'(Y_STEP) : '0;
               end
            end
         end
      end
   end

   // Screen y measured down from the top; clamp when the arc rises above row 0.
   always_comb begin
      box_x_pos = '0;
      box_y_pos = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         box_x_pos[i*10 +: 10] = x_q[i];
         if (y_off_q[i] > YW'(Y_FLOOR))
            box_y_pos[i*10 +: 10] = '0;
         else
            box_y_pos[i*10 +: 10] = XW'(YW'(Y_FLOOR) - y_off_q[i]);
      end
   end

   assign box_width  = 10'(BOX_WIDTH);
   assign box_height = 10'(BOX_HEIGHT);

endmodule

// File: tb/tb_collectible_pool.sv
// Directed bench for collectible_pool: spawn timing, flight, arc, miss/catch,
// hold cap, freeze and reset, with hand-computed expectations.
module tb_collectible_pool;

   logic          clk;
   logic          rst;
   logic          game_en;
   logic [3:0]    caught;
   logic [9:0]    y_amplitude_in;
   logic [3:0]    held_count;
   logic [39:0]   box_x_pos;
   logic [39:0]   box_y_pos;
   logic [9:0]    box_width;
   logic [9:0]    box_height;
   logic [3:0]    active;
   logic          spawn_pulse;
   logic          miss_pulse;

   int tests_run;
   int tests_failed;
   int en_edges;
   int spawns_seen;

   collectible_pool dut (
      .clk            (clk),
      .rst            (rst),
      .game_en        (game_en),
      .caught         (caught),
      .y_amplitude_in (y_amplitude_in),
      .held_count     (held_count),
      .box_x_pos      (box_x_pos),
      .box_y_pos      (box_y_pos),
      .box_width      (box_width),
      .box_height     (box_height),
      .active         (active),
      .spawn_pulse    (spawn_pulse),
      .miss_pulse     (miss_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] xs(input int i);
      return 32'(box_x_pos[i*10 +: 10]);
   endfunction

   function automatic logic [31:0] ys(input int i);
      return 32'(box_y_pos[i*10 +: 10]);
   endfunction

   // One clock edge, sampled 1ns later; counts enabled edges and spawns.
   task automatic tick();
      @(posedge clk);
      #1;
      if (game_en && !rst) en_edges++;
      if (spawn_pulse) spawns_seen++;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (en_edges < target && guard < 1000) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      en_edges       = 0;
      spawns_seen    = 0;
      rst            = 1'b1;
      game_en        = 1'b1;
      caught         = 4'b0000;
      y_amplitude_in = 10'd0;
      held_count     = 4'd0;

      tick();
      tick();
      check("rst_active", 32'(active), 0);
      check("rst_spawn",  32'(spawn_pulse), 0);
      check("rst_miss",   32'(miss_pulse), 0);
      check("rst_x0",     xs(0), 640);
      check("rst_y0",     ys(0), 235);
      check("rst_x3",     xs(3), 640);
      check("width",      32'(box_width), 30);
      check("height",     32'(box_height), 30);

      rst = 1'b0;
      en_edges = 0;
      run_to(20);
      check("e20_spawn",  32'(spawn_pulse), 0);
      check("e20_active", 32'(active), 0);
      run_to(21);
      check("e21_spawn",  32'(spawn_pulse), 1);
      check("e21_active", 32'(active), 1);
      check("e21_x0",     xs(0), 640);
      check("e21_y0",     ys(0), 235);
      y_amplitude_in = 10'd9;

      run_to(22);
      check("e22_spawn",  32'(spawn_pulse), 0);
      check("e22_x0",     xs(0), 634);
      check("e22_y0",     ys(0), 235);
      run_to(23);
      check("e23_x0",     xs(0), 628);
      check("e23_y0",     ys(0), 238);
      run_to(38);
      check("e38_y0",     ys(0), 283);
      run_to(39);
      check("e39_y0",     ys(0), 285);
      check("e39_x0",     xs(0), 532);
      run_to(41);
      check("e41_y0",     ys(0), 285);

      run_to(42);
      check("e42_spawn",  32'(spawn_pulse), 1);
      check("e42_active", 32'(active), 3);
      check("e42_x1",     xs(1), 640);
      check("e42_x0",     xs(0), 514);
      run_to(43);
      check("e43_y1",     ys(1), 232);
      run_to(45);
      check("e45_y1",     ys(1), 226);
      run_to(46);
      check("e46_y1",     ys(1), 226);
      run_to(47);
      check("e47_y1",     ys(1), 229);

      run_to(63);
      check("e63_spawn",  32'(spawn_pulse), 1);
      check("e63_active", 32'(active), 7);
      check("e63_x0",     xs(0), 388);

      game_en = 1'b0;
      repeat (10) tick();
      check("frz_spawn",  32'(spawn_pulse), 0);
      check("frz_x0",     xs(0), 388);
      check("frz_x1",     xs(1), 514);
      check("frz_y1",     ys(1), 277);
      check("frz_x2",     xs(2), 640);
      check("frz_active", 32'(active), 7);
      game_en = 1'b1;

      run_to(83);
      check("e83_spawn",  32'(spawn_pulse), 0);
      run_to(84);
      check("e84_spawn",  32'(spawn_pulse), 1);
      check("e84_active", 32'(active), 15);
      check("e84_x0",     xs(0), 262);
      run_to(105);
      check("e105_spawn", 32'(spawn_pulse), 0);
      check("e105_active",32'(active), 15);
      run_to(127);
      check("e127_x0",    xs(0), 4);
      check("e127_miss",  32'(miss_pulse), 0);
      run_to(128);
      check("e128_active",32'(active), 14);
      check("e128_miss",  32'(miss_pulse), 1);
      check("e128_x0",    xs(0), 640);
      check("e128_y0",    ys(0), 235);
      check("e128_x1",    xs(1), 124);
      check("e128_spawn", 32'(spawn_pulse), 0);
      run_to(129);
      check("e129_spawn", 32'(spawn_pulse), 1);
      check("e129_active",32'(active), 15);
      check("e129_miss",  32'(miss_pulse), 0);

      run_to(148);
      check("e148_x1",    xs(1), 4);
      caught = 4'b0010;
      run_to(149);
      caught = 4'b0000;
      check("catch_active", 32'(active), 13);
      check("catch_miss",   32'(miss_pulse), 0);
      check("catch_x1",     xs(1), 640);
      run_to(150);
      check("e150_spawn",   32'(spawn_pulse), 1);
      check("e150_active",  32'(active), 15);

      game_en = 1'b0;
      rst     = 1'b1;
      caught  = 4'b1111;
      tick();
      check("mrst_active", 32'(active), 0);
      check("mrst_x1",     xs(1), 640);
      check("mrst_y1",     ys(1), 235);
      check("mrst_miss",   32'(miss_pulse), 0);
      check("mrst_spawn",  32'(spawn_pulse), 0);

      rst         = 1'b0;
      caught      = 4'b0000;
      game_en     = 1'b1;
      held_count  = 4'd3;
      en_edges    = 0;
      spawns_seen = 0;
      run_to(100);
      check("hold_spawns", 32'(spawns_seen), 0);
      check("hold_active", 32'(active), 0);
      held_count = 4'd2;
      run_to(101);
      check("unhold_spawn",  32'(spawn_pulse), 1);
      check("unhold_active", 32'(active), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/collectible_pool.md
Name: collectible_pool

Overview:
- Multi-slot successor to the single-collectible controller. Manages up to NUM_SLOTS concurrent flying boxes, each with independent right-to-left motion and an up/down arc.
- A shared spawn scheduler allocates idle slots. Each slot latches its own arc amplitude at spawn.
- Sits between the game FSM/player logic (catch detect, hold count) and the VGA sprite renderer.

Parameters:
- NUM_SLOTS, 4, number of concurrent collectibles (1..8).
- BOX_WIDTH, 30, sprite width in pixels.
- BOX_HEIGHT, 30, sprite height in pixels.
- BOX_SPEED, 6, x decrement per enabled cycle.
- X_START, 640, x loaded at spawn/idle.
- Y_BASELINE, 315, floor line; y_pos = Y_BASELINE-BOX_HEIGHT-y_off.
- Y_INITIAL_OFFSET, 50, starting y_off at spawn.
- Y_STEP, 3, arc step per enabled cycle.
- SPAWN_GAP, 20, minimum enabled cycles between spawns.
- MAX_HELD, 3, spawning is blocked while held_count >= MAX_HELD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- game_en  in  1  advance enable; low freezes all state.
- caught  in  NUM_SLOTS  per-slot catch strobe from the collision block.
- y_amplitude_in  in  10  extra arc height, sampled at spawn.
- held_count  in  4  boxes currently held by the player.
- box_x_pos  out  10*NUM_SLOTS  packed x positions, slot i at [10i+9:10i].
- box_y_pos  out  10*NUM_SLOTS  packed y positions, same packing.
- box_width  out  10  constant BOX_WIDTH.
- box_height  out  10  constant BOX_HEIGHT.
- active  out  NUM_SLOTS  slot is flying/visible.
- spawn_pulse  out  1  one-cycle pulse on each spawn.
- miss_pulse  out  1  one-cycle pulse when any slot exits the left edge.

Behaviour:
- Synchronous, active-high reset on clk rising edge, regardless of game_en. Reset values:
  - all slots IDLE; active=0; x=X_START; y_off=Y_INITIAL_OFFSET; phase=UP; latched amp=0.
  - gap_cnt=0; spawn_pulse=0; miss_pulse=0.
- Reset during flight clears all slots in the same edge. Caught/miss events in that cycle are discarded.
- game_en=0: no register changes. Pulses drop to 0 and are not retriggered.
- Per-slot states: IDLE, UP, DOWN. active = (state != IDLE), registered.
- Scheduler:
  - gap_cnt increments each enabled cycle while < SPAWN_GAP, then saturates.
  - A grant occurs when gap_cnt == SPAWN_GAP, held_count < MAX_HELD, and at least one slot is IDLE.
  - Grant goes to the lowest-index IDLE slot. At most one grant per cycle.
  - On grant: gap_cnt <= 0; slot <= UP; x <= X_START; y_off <= Y_INITIAL_OFFSET; amp <= y_amplitude_in; spawn_pulse <= 1.
  - If blocked (hold cap reached or all slots busy), gap_cnt holds at SPAWN_GAP and the grant fires on the first eligible cycle.
- Flying slot, each enabled cycle, in priority order:
  1. caught[i]=1 -> IDLE, x <= X_START, active <= 0. No miss pulse.
  2. Else if x < BOX_SPEED -> IDLE, x <= X_START, miss_pulse <= 1. Guarantees no x underflow.
  3. Else x <= x - BOX_SPEED, and the arc updates:
     - UP: if y_off < Y_INITIAL_OFFSET+amp (11-bit compare), y_off += Y_STEP; else phase <= DOWN with y_off unchanged.
     - DOWN: y_off <= (y_off > Y_STEP) ? y_off - Y_STEP : 0. The slot stays at 0 until a catch or miss.
- caught[i] on an IDLE slot is ignored.
- A slot freed by catch/miss may be granted again in the same cycle only if it is the lowest IDLE slot per the pre-edge state. Freed slots become grantable next cycle.
- y_pos is combinational from the y_off register: Y_BASELINE-BOX_HEIGHT-y_off, clamped to 0 if y_off > Y_BASELINE-BOX_HEIGHT.
- An IDLE slot outputs its reset x/y. The renderer qualifies on active.
- Multiple simultaneous misses produce a single miss_pulse.

Test Plan:
- Reset, game_en=1, held_count=0, amp=0 -> spawn_pulse and active[0]=1 after the 21st enabled edge; x0=640, y0=235.
- Slot 0 flies uncaught -> x0 = 640-6k; after 106 moves x0=4; next edge active[0]=0, miss_pulse=1 for one cycle, x0=640.
- amp=0 -> first flying edge sets DOWN with y0 at 235; y_off steps 47,44,…,2, then 0, giving y0=285 and holding there.
- held_count=3 for 100 cycles -> no spawn; drop held_count to 2 -> spawn on the next enabled edge.
- NUM_SLOTS=4, no catches -> spawns every 21 cycles into slots 0,1,2,3. A 5th spawn waits until slot 0 misses, then goes to slot 0.
- caught[1] in the same cycle that slot 1 reaches x<6 -> catch wins and miss_pulse stays 0.
- Toggle game_en low for 10 cycles mid-flight -> x/y/gap_cnt frozen. Assert rst mid-flight -> all active=0 on the next edge.
